// File: rtl/slider_pkg.sv
// Shared definitions for the two-axis slider: axis FSM encoding and default geometry.
package slider_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN_POS = 2'd1,
    RUN_NEG = 2'd2
  } axisState_t;

  localparam int DEF_W           = 10;
  localparam int DEF_X_MIN       = 10;
  localparam int DEF_X_MAX       = 630;
  localparam int DEF_Y_MIN       = 10;
  localparam int DEF_Y_MAX       = 470;
  localparam int DEF_X_INIT      = 320;
  localparam int DEF_Y_INIT      = 240;
  localparam int DEF_MAX_SPEED   = 4;
  localparam int DEF_ACCEL_TICKS = 4;
  localparam int DEF_SPEED_W     = $clog2(DEF_MAX_SPEED + 1);

endpackage

// File: rtl/slider_motion_ctrl_if.sv
// Key, load and position signals between the key debouncers, the slider and the sprite renderer.
interface slider_motion_ctrl_if #(parameter int W = 10);

  logic         iFrame_tick;
  logic         iSlider_go;
  logic         iSlider_back;
  logic         iSlider_up;
  logic         iSlider_down;
  logic         iLoad;
  logic [W-1:0] iLoad_x;
  logic [W-1:0] iLoad_y;
  logic [W-1:0] oSlider_x;
  logic [W-1:0] oSlider_y;
  logic         oHit_x;
  logic         oHit_y;
  logic         oMoving;

  modport master (
    output iFrame_tick, iSlider_go, iSlider_back, iSlider_up, iSlider_down,
    output iLoad, iLoad_x, iLoad_y,
    input  oSlider_x, oSlider_y, oHit_x, oHit_y, oMoving
  );

  modport slave (
    input  iFrame_tick, iSlider_go, iSlider_back, iSlider_up, iSlider_down,
    input  iLoad, iLoad_x, iLoad_y,
    output oSlider_x, oSlider_y, oHit_x, oHit_y, oMoving
  );

endinterface

// File: rtl/slider_axis.sv
// One slider axis: direction FSM, accelerating speed, position with boundary clamp or wrap.
// Wrap-around at the boundaries instead of clamping is selected with `define SLIDER_WRAP_EN.
module slider_axis
  import slider_pkg::*;
#(
  parameter int W           = DEF_W,
  parameter int MIN         = DEF_X_MIN,
  parameter int MAX         = DEF_X_MAX,
  parameter int INIT        = DEF_X_INIT,
  parameter int MAX_SPEED   = DEF_MAX_SPEED,
  parameter int ACCEL_TICKS = DEF_ACCEL_TICKS
) (
  input  logic         iVGA_CLK,
  input  logic         iRST,
  input  logic         iTick,
  input  logic         iLoad,
  input  logic [W-1:0] iLoadVal,
  input  logic         iKeyPos,
  input  logic         iKeyNeg,
  output logic [W-1:0] oPos,
  output logic         oHit,
  output logic         oBusy
);

  localparam int SW = $clog2(MAX_SPEED + 1);
  localparam int CW = $clog2(ACCEL_TICKS + 1);
  localparam logic [W:0] MIN_W = (W+1)'(MIN);
  localparam logic [W:0] MAX_W = (W+1)'(MAX);
  localparam logic [W:0] ONE_W = (W+1)'(1);

  axisState_t    state, stateNext, want;
  logic [SW-1:0] speed, speedNext, speedBase;
  logic [CW-1:0] cnt, cntNext, cntInc;
  logic [W-1:0]  pos, posNext;
  logic          hit, hitNext;
  logic          onlyPos, onlyNeg, dirNeg, move;
  logic [W:0]    sum;

  always_ff @(posedge iVGA_CLK or posedge iRST) begin
    if (iRST) begin
      state <= IDLE;
      speed <= '0;
      cnt   <= '0;
      pos   <= W'(INIT);
      hit   <= 1'b0;
    end else begin
      state <= stateNext;
      speed <= speedNext;
      cnt   <= cntNext;
      pos   <= posNext;
      hit   <= hitNext;
    end
  end

  // The entry tick counts as the first tick of continuous motion toward acceleration.
  always_comb begin
    stateNext = state;
    speedNext = speed;
    cntNext   = cnt;
    posNext   = pos;
    hitNext   = 1'b0;
    onlyPos   = iKeyPos & ~iKeyNeg;
    onlyNeg   = iKeyNeg & ~iKeyPos;
    dirNeg    = onlyNeg;
    want      = onlyNeg ? RUN_NEG : RUN_POS;
    speedBase = (state != want) ? SW'(1) : speed;
    cntInc    = (state != want) ? CW'(1) : cnt + CW'(1);
    move      = 1'b0;
    sum       = '0;
    if (iLoad) begin
      if (iLoadVal >= W'(MAX))
        posNext = W'(MAX);
      else if (iLoadVal <= W'(MIN))
        posNext = W'(MIN);
      else
        posNext = iLoadVal;
      stateNext = IDLE;
      speedNext = '0;
      cntNext   = '0;
    end else if (iTick) begin
      if (onlyPos || onlyNeg) begin
        stateNext = want;
        move      = 1'b1;
        if (cntInc >= CW'(ACCEL_TICKS)) begin
          cntNext   = '0;
          speedNext = (speedBase == SW'(MAX_SPEED)) ? speedBase : speedBase + SW'(1);
        end else begin
          cntNext   = cntInc;
          speedNext = speedBase;
        end
      end else begin
        stateNext = IDLE;
        speedNext = '0;
        cntNext   = '0;
      end
    end
    if (move) begin
      // Bit W of sum flags an underflow below zero when moving negative.
      sum     = dirNeg ? ({1'b0, pos} - {{(W+1-SW){1'b0}}, speedBase})
                       : ({1'b0, pos} + {{(W+1-SW){1'b0}}, speedBase});
      posNext = sum[W-1:0];
`ifdef SLIDER_WRAP_EN
      if (!dirNeg && sum > MAX_W) begin
        posNext = W'(MIN_W + (sum - MAX_W - ONE_W));
        hitNext = 1'b1;
      end else if (dirNeg && (sum[W] || sum < MIN_W)) begin
        posNext = W'(MAX_W - (MIN_W - sum - ONE_W));
        hitNext = 1'b1;
      end
`else
      if ((!dirNeg && sum >= MAX_W) || (dirNeg && (sum[W] || sum <= MIN_W))) begin
        posNext   = dirNeg ? W'(MIN) : W'(MAX);
        hitNext   = 1'b1;
        stateNext = IDLE;
        speedNext = '0;
        cntNext   = '0;
      end
`endif
    end
  end

  always_comb begin
    oBusy = (state != IDLE);
    oPos  = pos;
    oHit  = hit;
  end

endmodule

// File: rtl/slider_motion_ctrl.sv
// Two-axis slider position generator; x keyed by go/back, y by down/up, paced by the frame tick.
// Boundary wrap-around instead of clamping is selected with `define SLIDER_WRAP_EN.
module slider_motion_ctrl
  import slider_pkg::*;
#(
  parameter int W           = DEF_W,
  parameter int X_MIN       = DEF_X_MIN,
  parameter int X_MAX       = DEF_X_MAX,
  parameter int Y_MIN       = DEF_Y_MIN,
  parameter int Y_MAX       = DEF_Y_MAX,
  parameter int X_INIT      = DEF_X_INIT,
  parameter int Y_INIT      = DEF_Y_INIT,
  parameter int MAX_SPEED   = DEF_MAX_SPEED,
  parameter int ACCEL_TICKS = DEF_ACCEL_TICKS
) (
  input  logic                 iVGA_CLK,
  input  logic                 iRST,
  slider_motion_ctrl_if.slave  bus
);

  logic xBusy, yBusy;

  slider_axis #(
    .W(W), .MIN(X_MIN), .MAX(X_MAX), .INIT(X_INIT),
    .MAX_SPEED(MAX_SPEED), .ACCEL_TICKS(ACCEL_TICKS)
  ) axisX (
    .iVGA_CLK (iVGA_CLK),
    .iRST     (iRST),
    .iTick    (bus.iFrame_tick),
    .iLoad    (bus.iLoad),
    .iLoadVal (bus.iLoad_x),
    .iKeyPos  (bus.iSlider_go),
    .iKeyNeg  (bus.iSlider_back),
    .oPos     (bus.oSlider_x),
    .oHit     (bus.oHit_x),
    .oBusy    (xBusy)
  );

  // Screen y grows downward, so "down" is the positive direction.
  slider_axis #(
    .W(W), .MIN(Y_MIN), .MAX(Y_MAX), .INIT(Y_INIT),
    .MAX_SPEED(MAX_SPEED), .ACCEL_TICKS(ACCEL_TICKS)
  ) axisY (
    .iVGA_CLK (iVGA_CLK),
    .iRST     (iRST),
    .iTick    (bus.iFrame_tick),
    .iLoad    (bus.iLoad),
    .iLoadVal (bus.iLoad_y),
    .iKeyPos  (bus.iSlider_down),
    .iKeyNeg  (bus.iSlider_up),
    .oPos     (bus.oSlider_y),
    .oHit     (bus.oHit_y),
    .oBusy    (yBusy)
  );

  assign bus.oMoving = xBusy | yBusy;

endmodule

// File: tb/tb_slider_motion_ctrl.sv
// Directed self-checking bench for slider_motion_ctrl with hand-computed positions.
// Wrap-mode vectors are compiled in when SLIDER_WRAP_EN is defined.
module tb_slider_motion_ctrl;

  logic iVGA_CLK = 1'b0;
  logic iRST     = 1'b1;
  int   checks   = 0;
  int   errors   = 0;

  slider_motion_ctrl_if #(.W(10)) bus ();

  slider_motion_ctrl dut (
    .iVGA_CLK (iVGA_CLK),
    .iRST     (iRST),
    .bus      (bus)
  );

  always #5 iVGA_CLK = ~iVGA_CLK;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed != expected) begin
      errors++;
      $display("[TB] FAIL %s observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // One clock cycle with the given keys/tick/load; outputs are sampled 1 ns after the edge.
  task automatic applyStimulus(input logic go, input logic back, input logic up, input logic down,
                               input logic tick, input logic load, input int lx, input int ly);
    @(negedge iVGA_CLK);
    bus.iSlider_go   = go;
    bus.iSlider_back = back;
    bus.iSlider_up   = up;
    bus.iSlider_down = down;
    bus.iFrame_tick  = tick;
    bus.iLoad        = load;
    bus.iLoad_x      = 10'(lx);
    bus.iLoad_y      = 10'(ly);
    @(posedge iVGA_CLK);
    #1;
  endtask

  task automatic loadPos(input int lx, input int ly);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, lx, ly);
  endtask

  int xSeqRun[6]   = '{321, 322, 323, 324, 326, 328};
  int xSeqFast[8]  = '{101, 102, 103, 104, 106, 108, 110, 112};
  int xSeqWrap[7]  = '{622, 623, 624, 625, 627, 629, 10};

  initial begin
    bus.iFrame_tick = 0; bus.iSlider_go = 0; bus.iSlider_back = 0; bus.iSlider_up = 0;
    bus.iSlider_down = 0; bus.iLoad = 0; bus.iLoad_x = '0; bus.iLoad_y = '0;
    repeat (2) @(posedge iVGA_CLK);
    #1;
    checkOutput("rst_x", int'(bus.oSlider_x), 320);
    checkOutput("rst_y", int'(bus.oSlider_y), 240);
    checkOutput("rst_moving", int'(bus.oMoving), 0);
    checkOutput("rst_hit", int'({bus.oHit_x, bus.oHit_y}), 0);
    @(negedge iVGA_CLK);
    iRST = 1'b0;

    // Acceleration from rest: speed 2 is first used on the fifth tick.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
      checkOutput($sformatf("run_x%0d", i), int'(bus.oSlider_x), xSeqRun[i]);
    end
    checkOutput("run_moving", int'(bus.oMoving), 1);
    checkOutput("run_y_hold", int'(bus.oSlider_y), 240);
    repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    checkOutput("idle_hold_x", int'(bus.oSlider_x), 328);
    checkOutput("idle_hold_moving", int'(bus.oMoving), 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
    checkOutput("release_x", int'(bus.oSlider_x), 328);
    checkOutput("release_moving", int'(bus.oMoving), 0);

`ifndef SLIDER_WRAP_EN
    // Clamp at the right edge, then a fresh press against the wall.
    loadPos(628, 240);
    checkOutput("load628_x", int'(bus.oSlider_x), 628);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
    checkOutput("edge_x629", int'(bus.oSlider_x), 629);
    checkOutput("edge_hit0", int'(bus.oHit_x), 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
    checkOutput("edge_x630", int'(bus.oSlider_x), 630);
    checkOutput("edge_hit1", int'(bus.oHit_x), 1);
    checkOutput("edge_idle", int'(bus.oMoving), 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    checkOutput("edge_hit_drop", int'(bus.oHit_x), 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
    checkOutput("edge_reclamp_x", int'(bus.oSlider_x), 630);
    checkOutput("edge_rehit", int'(bus.oHit_x), 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    checkOutput("edge_rehit_drop", int'(bus.oHit_x), 0);
`endif

    // Reach speed 3, stop with both keys, then reverse at speed 1.
    loadPos(100, 240);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
      checkOutput($sformatf("fast_x%0d", i), int'(bus.oSlider_x), xSeqFast[i]);
    end
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
    checkOutput("both_x", int'(bus.oSlider_x), 112);
    checkOutput("both_moving", int'(bus.oMoving), 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
    checkOutput("back_x1", int'(bus.oSlider_x), 111);
    checkOutput("back_moving", int'(bus.oMoving), 1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
    checkOutput("back_x2", int'(bus.oSlider_x), 110);

    // Load wins over a coincident tick and is clamped into range.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 700, 5);
    checkOutput("ldclamp_x", int'(bus.oSlider_x), 630);
    checkOutput("ldclamp_y", int'(bus.oSlider_y), 10);
    checkOutput("ldclamp_hit", int'({bus.oHit_x, bus.oHit_y}), 0);
    checkOutput("ldclamp_moving", int'(bus.oMoving), 0);

`ifndef SLIDER_WRAP_EN
    // Both axes land exactly on a boundary in the same tick.
    loadPos(629, 469);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0, 0);
    checkOutput("dual_x", int'(bus.oSlider_x), 630);
    checkOutput("dual_y", int'(bus.oSlider_y), 470);
    checkOutput("dual_hits", int'({bus.oHit_x, bus.oHit_y}), 3);
    loadPos(11, 11);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 0, 0);
    checkOutput("low_x", int'(bus.oSlider_x), 10);
    checkOutput("low_y", int'(bus.oSlider_y), 10);
    checkOutput("low_hits", int'({bus.oHit_x, bus.oHit_y}), 3);
    checkOutput("low_moving", int'(bus.oMoving), 0);
`else
    // Wrap mode: 631 wraps to 10 at speed 2 and the axis keeps running.
    loadPos(621, 240);
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
      checkOutput($sformatf("wrap_x%0d", i), int'(bus.oSlider_x), xSeqWrap[i]);
      checkOutput($sformatf("wrap_hit%0d", i), int'(bus.oHit_x), (i == 6) ? 1 : 0);
    end
    checkOutput("wrap_moving", int'(bus.oMoving), 1);
    loadPos(10, 240);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
    checkOutput("wrapneg_x", int'(bus.oSlider_x), 630);
    checkOutput("wrapneg_hit", int'(bus.oHit_x), 1);
`endif

    // Asynchronous reset in the middle of motion.
    loadPos(400, 240);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0, 0);
    checkOutput("pre_rst_x", int'(bus.oSlider_x), 402);
    #2;
    iRST = 1'b1;
    #1;
    checkOutput("async_rst_x", int'(bus.oSlider_x), 320);
    checkOutput("async_rst_y", int'(bus.oSlider_y), 240);
    checkOutput("async_rst_moving", int'(bus.oMoving), 0);
    checkOutput("async_rst_hit", int'({bus.oHit_x, bus.oHit_y}), 0);
    @(negedge iVGA_CLK);
    iRST = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
